// File: rtl/pc_sequencer.sv
// Program-counter control sequencer: fetches and decodes opcodes, drives PC hold/increment/load
// and keeps a small return-address stack for CALL/RET.
module pc_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_data,
  input  logic [7:0] pc,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       resume,
  output logic       doJump,
  output logic       immediate,
  output logic       dbus_sel,
  output logic [7:0] dbus_out,
  output logic [7:0] ir,
  output logic       exec,
  output logic       operand_valid,
  output logic       halted,
  output logic       fault
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {FETCH, EXEC1, OPERAND, RETURN, HALTED, FAULT} state_t;

  state_t        state;
  state_t        fetch_next;
  logic [7:0]    ir_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_m1;
  logic [7:0]    stack [DEPTH];
  logic [7:0]    ret_addr;
  logic          is_jmp, is_call, taken, full, empty, push, pop;

  always_comb begin
    is_jmp   = (ir_q[7:2] == 6'b100000);
    is_call  = (ir_q == 8'h84);
    case (ir_q[1:0])
      2'd0:    taken = 1'b1;
      2'd1:    taken = flag_z;
      2'd2:    taken = flag_c;
      default: taken = ~flag_z;
    endcase
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    count_m1 = count - CW'(1);
    ret_addr = stack[count_m1[AW-1:0]];
    // Stack commits are gated by reset so an aborted CALL/RET leaves no trace.
    push     = !reset && (state == OPERAND) && is_call && !full;
    pop      = !reset && (state == RETURN) && !empty;

    if (!rom_data[7])            fetch_next = rom_data[6] ? OPERAND : EXEC1;
    else if (rom_data <= 8'h84)  fetch_next = OPERAND;
    else if (rom_data == 8'h85)  fetch_next = RETURN;
    else if (rom_data == 8'h86)  fetch_next = HALTED;
    else                         fetch_next = EXEC1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ir_q  <= '0;
      count <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir_q  <= rom_data;
          state <= fetch_next;
        end
        EXEC1:   state <= FETCH;
        OPERAND: state <= (is_call && full) ? FAULT : FETCH;
        RETURN:  state <= empty ? FAULT : FETCH;
        HALTED:  if (resume) state <= FETCH;
        FAULT:   state <= FAULT;
        default: state <= FETCH;
      endcase
      if (push)     count <= count + CW'(1);
      else if (pop) count <= count_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[count[AW-1:0]] <= pc + 8'd1;
  end

  always_comb begin
    doJump        = 1'b0;
    immediate     = 1'b0;
    dbus_sel      = 1'b0;
    dbus_out      = '0;
    ir            = '0;
    exec          = 1'b0;
    operand_valid = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    if (!reset) begin
      ir = ir_q;
      case (state)
        FETCH: immediate = 1'b1;
        EXEC1: exec = ~ir_q[7];
        OPERAND: begin
          if (!ir_q[7]) begin
            exec          = 1'b1;
            operand_valid = 1'b1;
            immediate     = 1'b1;
          end else if (is_jmp) begin
            doJump    = taken;
            immediate = ~taken;
          end else if (is_call) begin
            doJump = ~full;
          end
        end
        RETURN: begin
          if (!empty) begin
            doJump   = 1'b1;
            dbus_sel = 1'b1;
            dbus_out = ret_addr;
          end
        end
        HALTED: halted = 1'b1;
        FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
